// File: rtl/bp_pkg.sv
// Shared types and default sizing for the branch-history checkpoint block and its GHR.
// The optional statistics counters are enabled by defining BP_CKPT_STATS_EN.
package bp_pkg;

  localparam int HIST_LEN_DEFAULT = 32;
  localparam int DEPTH_DEFAULT    = 8;

  typedef enum logic {
    NORMAL,
    RESTORE
  } ckpt_state_e;

  typedef logic [$clog2(DEPTH_DEFAULT)-1:0] ckpt_ptr_t;

endpackage

// File: rtl/bp_hist_checkpoint_if.sv
// Predict/resolve/restore signal bundle between the frontend, the resolve path and the checkpoint store.
// master = the pipeline side driving pushes and resolves, slave = bp_hist_checkpoint.
interface bp_hist_checkpoint_if #(
  parameter int HIST_LEN = 32,
  parameter int DEPTH    = 8
);

  logic                       push_valid_i;
  logic                       push_ready_o;
  logic [HIST_LEN-1:0]        push_hist_i;
  logic                       resolve_valid_i;
  logic                       resolve_mispred_i;
  logic                       resolve_taken_i;
  logic                       restore_we_o;
  logic [HIST_LEN-1:0]        restore_hist_o;
  logic [$clog2(DEPTH):0]     count_o;
  logic                       empty_o;
  logic                       full_o;

  modport master (
    output push_valid_i, push_hist_i, resolve_valid_i, resolve_mispred_i, resolve_taken_i,
    input  push_ready_o, restore_we_o, restore_hist_o, count_o, empty_o, full_o
  );

  modport slave (
    input  push_valid_i, push_hist_i, resolve_valid_i, resolve_mispred_i, resolve_taken_i,
    output push_ready_o, restore_we_o, restore_hist_o, count_o, empty_o, full_o
  );

endinterface

// File: rtl/bp_ckpt_ram.sv
// DEPTH x HIST_LEN flop array holding GHR snapshots: one write port at the tail, one async read at the head.
module bp_ckpt_ram #(
  parameter int HIST_LEN = 32,
  parameter int DEPTH    = 8
) (
  input  logic                     clk_i,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [HIST_LEN-1:0]      i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [HIST_LEN-1:0]      o_rdata
);

  logic [HIST_LEN-1:0] r_mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/bp_hist_checkpoint.sv
// GHR checkpoint FIFO: snapshots history per predicted branch and rewrites the GHR on a mispredict.
// Define BP_CKPT_STATS_EN to add saturating mispredict and push-stall counters.
module bp_hist_checkpoint
  import bp_pkg::*;
#(
  parameter int HIST_LEN = HIST_LEN_DEFAULT,
  parameter int DEPTH    = DEPTH_DEFAULT
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  bp_hist_checkpoint_if.slave  bus
`ifdef BP_CKPT_STATS_EN
  ,
  output logic [31:0]          mispred_cnt_o,
  output logic [31:0]          stall_cnt_o
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]    r_head;
  logic [PTR_W-1:0]    r_tail;
  logic [CNT_W-1:0]    r_count;
  logic [HIST_LEN-1:0] r_restoreHist;
  ckpt_state_e         r_state;
  ckpt_state_e         w_stateNext;

  logic                w_empty;
  logic                w_full;
  logic                w_pushReady;
  logic                w_restoreWe;
  logic                w_resolveOk;
  logic                w_mispredAcc;
  logic                w_correctAcc;
  logic                w_pushAcc;
  logic [HIST_LEN-1:0] w_headHist;

  assign w_empty      = (r_count == '0);
  assign w_full       = (r_count == CNT_W'(DEPTH));
  assign w_resolveOk  = bus.resolve_valid_i && !w_empty && (r_state == NORMAL);
  assign w_mispredAcc = w_resolveOk && bus.resolve_mispred_i;
  assign w_correctAcc = w_resolveOk && !bus.resolve_mispred_i;
  // A push racing a mispredict is on the wrong path, so the flush wins.
  assign w_pushAcc    = bus.push_valid_i && w_pushReady && !w_mispredAcc;

  bp_ckpt_ram #(
    .HIST_LEN (HIST_LEN),
    .DEPTH    (DEPTH)
  ) u_ram (
    .clk_i    (clk_i),
    .i_we     (w_pushAcc),
    .i_waddr  (r_tail),
    .i_wdata  (bus.push_hist_i),
    .i_raddr  (r_head),
    .o_rdata  (w_headHist)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= NORMAL;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    w_restoreWe = 1'b0;
    w_pushReady = 1'b0;
    case (r_state)
      NORMAL: begin
        w_pushReady = !w_full;
        if (w_mispredAcc) begin
          w_stateNext = RESTORE;
        end
      end
      RESTORE: begin
        w_restoreWe = 1'b1;
        w_stateNext = NORMAL;
      end
      default: w_stateNext = NORMAL;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (w_mispredAcc) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_pushAcc) begin
        r_tail <= r_tail + 1'b1;
      end
      if (w_correctAcc) begin
        r_head <= r_head + 1'b1;
      end
      case ({w_pushAcc, w_correctAcc})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Corrected history mirrors the GHR shift-left with the actual outcome in bit 0.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_restoreHist <= '0;
    end else if (w_mispredAcc) begin
      r_restoreHist <= {w_headHist[HIST_LEN-2:0], bus.resolve_taken_i};
    end
  end

  assign bus.push_ready_o   = w_pushReady;
  assign bus.restore_we_o   = w_restoreWe;
  assign bus.restore_hist_o = r_restoreHist;
  assign bus.count_o        = r_count;
  assign bus.empty_o        = w_empty;
  assign bus.full_o         = w_full;

`ifdef BP_CKPT_STATS_EN
  logic [31:0] r_mispredCnt;
  logic [31:0] r_stallCnt;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_mispredCnt <= '0;
      r_stallCnt   <= '0;
    end else begin
      if (w_mispredAcc && (r_mispredCnt != 32'hFFFF_FFFF)) begin
        r_mispredCnt <= r_mispredCnt + 32'd1;
      end
      if (bus.push_valid_i && !w_pushReady && (r_stallCnt != 32'hFFFF_FFFF)) begin
        r_stallCnt <= r_stallCnt + 32'd1;
      end
    end
  end

  assign mispred_cnt_o = r_mispredCnt;
  assign stall_cnt_o   = r_stallCnt;
`endif

endmodule
